// File: rtl/serial_operand_reg.sv
// rtl/serial_operand_reg.sv - serial-to-parallel operand input stage for the FP adder
module serial_operand_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             serial_in,
  input  logic             serial_valid_in,
  input  logic             frame_start_in,
  input  logic             operands_read_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             operands_rdy,
  output logic             input_rdy,
  output logic             overrun_err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_A = 2'd1;
  localparam logic [1:0] LOAD_B = 2'd2;
  localparam logic [1:0] FULL   = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             last_bit;

  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign input_rdy = (state != FULL);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      cnt          <= '0;
      a_sh         <= '0;
      b_sh         <= '0;
      a_out        <= '0;
      b_out        <= '0;
      operands_rdy <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Bits without a frame marker are line noise before sync; drop them silently.
          if (serial_valid_in && frame_start_in) begin
            a_sh  <= {serial_in, a_sh[WIDTH-1:1]};
            cnt   <= CW'(1);
            state <= LOAD_A;
          end
        end
        LOAD_A, LOAD_B: begin
          if (serial_valid_in) begin
            if (frame_start_in) begin
              // Resync: stale A bits are shifted out before the frame completes.
              a_sh  <= {serial_in, a_sh[WIDTH-1:1]};
              cnt   <= CW'(1);
              state <= LOAD_A;
            end else if (state == LOAD_A) begin
              a_sh <= {serial_in, a_sh[WIDTH-1:1]};
              if (last_bit) begin
                cnt   <= '0;
                state <= LOAD_B;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              b_sh <= {serial_in, b_sh[WIDTH-1:1]};
              if (last_bit) begin
                a_out        <= a_sh;
                b_out        <= {serial_in, b_sh[WIDTH-1:1]};
                operands_rdy <= 1'b1;
                cnt          <= '0;
                state        <= FULL;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
        end
        default: begin
          if (serial_valid_in) begin
            overrun_err <= 1'b1;
          end
          if (operands_read_in) begin
            operands_rdy <= 1'b0;
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/serial_operand_reg.md
# serial_operand_reg

Serial-to-parallel input stage of the floating-point adder. It receives two half-precision operands, A then B, as one LSB-first bit stream. It presents them as stable parallel words with a ready/acknowledge handshake to the adder core. It is the upstream counterpart of the output serializer, which takes the adder result back to a serial stream.

## Interface
- WIDTH, 16, width of each operand in bits.
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, asynchronous, active-low.
- serial_in  input  1  serial data bit, LSB first, A then B.
- serial_valid_in  input  1  qualifies serial_in on this edge.
- frame_start_in  input  1  marks the current valid bit as A[0]; ignored when serial_valid_in=0.
- operands_read_in  input  1  consumer acknowledge; meaningful only while operands_rdy=1.
- a_out  output  WIDTH  operand A, stable while operands_rdy=1.
- b_out  output  WIDTH  operand B, stable while operands_rdy=1.
- operands_rdy  output  1  a complete A/B pair is held.
- input_rdy  output  1  block accepts serial bits (state is not FULL).
- overrun_err  output  1  sticky flag: a valid bit arrived while input_rdy=0.

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, FULL. A 4-bit counter (log2 WIDTH) gives the bit index.
- **IDLE**
  - A valid bit with frame_start_in=1 is stored as A[0]; counter becomes 1; next state is LOAD_A.
  - A valid bit with frame_start_in=0 is discarded; no flag is set.
- **LOAD_A**
  - Each valid bit shifts into the A shift register: a_sh <= {serial_in, a_sh[WIDTH-1:1]}.
  - After the WIDTH-th A bit, the counter returns to 0 and the next state is LOAD_B.
- **LOAD_B**
  - Same shifting into b_sh.
  - The edge that samples the WIDTH-th B bit does all of the following together:
    - a_out <= a_sh;
    - b_out <= {serial_in, b_sh[WIDTH-1:1]};
    - next state is FULL.
- **Resync:** in LOAD_A or LOAD_B, a valid bit with frame_start_in=1 discards the partial frame. That bit becomes A[0], the counter is set to 1, and the state is LOAD_A.
- **FULL**
  - operands_rdy=1 and input_rdy=0.
  - operands_read_in=1 moves the state to IDLE at the next edge.
  - A valid bit is dropped and sets overrun_err, including when it coincides with operands_read_in.
- operands_read_in is ignored outside FULL.
- a_out and b_out change only on entry to FULL. They keep their values through IDLE and loading until the next complete frame.
- overrun_err clears only on reset.
- Partial operands are never visible on a_out or b_out.

## Timing
- **Reset values** (rst_in low, immediate, no clock needed):
  - state IDLE, counter 0, shift registers 0;
  - a_out=0, b_out=0;
  - operands_rdy=0, input_rdy=1, overrun_err=0.
- **Reset mid-frame:** the partial frame is lost. After rst_in deasserts, the block needs a fresh frame_start.
- **Throughput:** at most one bit per cycle. Gaps in serial_valid_in are allowed at any point.
- **Latency:** operands_rdy is high after the rising edge that samples the 2·WIDTH-th valid bit, with zero extra cycles.
- **Handshake**
  - The consumer may assert operands_read_in in the first cycle operands_rdy is high.
  - operands_rdy and input_rdy=0 drop after the edge that samples operands_read_in=1.
- **Back-to-back frames:** a frame_start bit can be accepted on the edge immediately after the read edge. Minimum frame period is 2·WIDTH + 1 cycles.
- **Outputs:** all outputs are registered except input_rdy, which is decoded from state.

## Test plan
- **Basic frame:** reset, then a contiguous frame A=0x3C00, B=0x4000 with frame_start on the first bit.
  - operands_rdy=1 right after the 32nd edge, a_out=0x3C00, b_out=0x4000, input_rdy=0.
  - operands_read_in pulse → operands_rdy=0 and input_rdy=1 one edge later; a_out and b_out hold.
- **Gapped stream:** A=0xFFFF, B=0x0001 with serial_valid_in low on every other cycle.
  - operands_rdy stays 0 until the 32nd valid bit, then a_out=0xFFFF, b_out=0x0001.
- **Stray bits and resync:**
  - 5 valid bits without frame_start in IDLE, then a frame A=0x1234, B=0xABCD → a_out=0x1234, b_out=0xABCD.
  - Repeat with frame_start reasserted after 20 bits of a bad frame → same result.
- **Overrun:** in FULL, drive one valid bit, including one edge where operands_read_in=1 at the same time.
  - overrun_err=1, a_out and b_out unchanged, state returns to IDLE after the read.
  - overrun_err stays 1 until rst_in is driven low.
- **Async reset mid-frame:** drive rst_in low between edges after 20 bits.
  - Outputs take their reset values immediately.
  - A following full frame A=0x7BFF, B=0x8001 completes correctly.
- **Back-to-back frames:** read in the first cycle operands_rdy is high, then frame_start on the very next cycle.
  - Second pair A=0x0400, B=0xFC00 appears with no lost bits.
